phase2speed_win: RTL and testbench

Parametrised successor phase-to-speed converter for the Hilbert-filter demodulator chain. It averages signed phase samples over 2^meanlen samples and scales the mean to a signed speed word. Two averaging modes: block (decimating, one output per window) and sliding (one output per sample once the window is full). Output scaling saturates and reports overflow.

---
 rtl/phase2speed_win_if.sv | 26 ++
 rtl/phase2speed_win.sv | 218 +++++++++++++++++++++
 tb/tb_phase2speed_win.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase2speed_win_if.sv
// Sample/config/result bundle for the windowed phase-to-speed converter.
// master drives samples and configuration; slave is the converter itself.
interface phase2speed_win_if #(
    parameter int PHASE_W = 19,
    parameter int SPEED_W = 16
);
    logic                       clear;
    logic                       mode;
    logic [3:0]                 meanlen;
    logic                       sample;
    logic signed [PHASE_W-1:0]  phase;
    logic signed [SPEED_W-1:0]  speed;
    logic                       speed_valid;
    logic                       sat;
    logic                       filling;

    modport master (
        output clear, mode, meanlen, sample, phase,
        input  speed, speed_valid, sat, filling
    );

    modport slave (
        input  clear, mode, meanlen, sample, phase,
        output speed, speed_valid, sat, filling
    );
endinterface

// File: rtl/phase2speed_win.sv
// Windowed phase-to-speed converter: block or sliding mean over 2^meanlen
// phase samples, scaled and saturated to a signed speed word.
module phase2speed_win #(
    parameter int          PHASE_W     = 19,
    parameter int          SPEED_W     = 16,
    parameter int          MAX_LOG2    = 10,
    parameter int unsigned SCALE       = 20450,
    parameter int          SCALE_SHIFT = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    phase2speed_win_if.slave     bus
);

    localparam int DEPTH  = 2 ** MAX_LOG2;
    localparam int ACC_W  = PHASE_W + MAX_LOG2;
    localparam int PROD_W = PHASE_W + 33;

    localparam logic [3:0]                 MAX_L2_C = 4'(MAX_LOG2);
    localparam logic [MAX_LOG2-1:0]        ONE_C    = {{(MAX_LOG2-1){1'b0}}, 1'b1};
    localparam logic signed [32:0]         SCALE_S  = {1'b0, SCALE[31:0]};
    localparam logic signed [PROD_W-1:0]   SPD_MAX  = {{(PROD_W-SPEED_W+1){1'b0}}, {(SPEED_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0]   SPD_MIN  = {{(PROD_W-SPEED_W+1){1'b1}}, {(SPEED_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_DUMP = 2'd1,
        ST_FILL = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] r;
        if (len > MAX_L2_C) begin
            r = MAX_L2_C;
        end else begin
            r = len;
        end
        return r;
    endfunction

    function automatic logic [MAX_LOG2-1:0] len_mask(input logic [3:0] l2);
        logic [MAX_LOG2-1:0] m;
        for (int i = 0; i < MAX_LOG2; i++) begin
            m[i] = (4'(i) < l2);
        end
        return m;
    endfunction

    // Result is {clipped, value}.
    function automatic logic [SPEED_W:0] sat_speed(input logic signed [PROD_W-1:0] v);
        logic [SPEED_W:0] r;
        if (v > SPD_MAX) begin
            r = {1'b1, SPD_MAX[SPEED_W-1:0]};
        end else if (v < SPD_MIN) begin
            r = {1'b1, SPD_MIN[SPEED_W-1:0]};
        end else begin
            r = {1'b0, v[SPEED_W-1:0]};
        end
        return r;
    endfunction

    state_t                     state_r;
    logic                       mode_r;
    logic [3:0]                 log2n_r;
    logic [MAX_LOG2-1:0]        mask_r;
    logic signed [ACC_W-1:0]    sum_r;
    logic [MAX_LOG2-1:0]        cnt_r;
    logic [MAX_LOG2-1:0]        wp_r;
    logic                       filling_r;
    logic signed [ACC_W-1:0]    win_sum_r;
    logic [3:0]                 win_shift_r;
    logic                       win_done_r;
    logic signed [PHASE_W-1:0]  mean_r;
    logic                       mean_v_r;
    logic signed [SPEED_W-1:0]  speed_r;
    logic                       speed_valid_r;
    logic                       sat_r;

    logic signed [PHASE_W-1:0]  win_buf_r [0:DEPTH-1];

    logic signed [ACC_W-1:0]    phase_ext_s;
    logic signed [ACC_W-1:0]    old_ext_s;
    logic signed [ACC_W-1:0]    sum_add_s;
    logic signed [ACC_W-1:0]    sum_slide_s;
    logic                       last_s;
    logic [MAX_LOG2-1:0]        wp_next_s;
    logic [MAX_LOG2-1:0]        cnt_next_s;
    logic signed [ACC_W-1:0]    mean_wide_s;
    logic signed [PHASE_W-1:0]  mean_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [PROD_W-1:0]   scaled_s;
    logic [SPEED_W:0]           sat_res_s;

    // Accumulator arithmetic, window bookkeeping and the mean/scale datapath.
    always_comb begin
        phase_ext_s = {{MAX_LOG2{bus.phase[PHASE_W-1]}}, bus.phase};
        old_ext_s   = {{MAX_LOG2{win_buf_r[wp_r][PHASE_W-1]}}, win_buf_r[wp_r]};
        sum_add_s   = sum_r + phase_ext_s;
        sum_slide_s = sum_add_s - old_ext_s;
        last_s      = (cnt_r == mask_r);
        wp_next_s   = (wp_r + ONE_C) & mask_r;
        cnt_next_s  = cnt_r + ONE_C;
        mean_wide_s = win_sum_r >>> win_shift_r;
        mean_s      = mean_wide_s[PHASE_W-1:0];
        prod_s      = $signed({{33{mean_r[PHASE_W-1]}}, mean_r})
                    * $signed({{PHASE_W{1'b0}}, SCALE_S});
        scaled_s    = prod_s >>> SCALE_SHIFT;
        sat_res_s   = sat_speed(scaled_s);
    end

    // Sample history for the sliding window; FILL writes every slot before RUN reads one.
    always_ff @(posedge clock) begin
        if (!reset && !bus.clear && bus.sample && mode_r) begin
            win_buf_r[wp_r] <= bus.phase;
        end
    end

    // Window FSM, accumulator and the two registered pipeline stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r        <= bus.mode;
            log2n_r       <= clamp_len(bus.meanlen);
            mask_r        <= len_mask(clamp_len(bus.meanlen));
            state_r       <= bus.mode ? ST_FILL : ST_ACC;
            sum_r         <= '0;
            cnt_r         <= '0;
            wp_r          <= '0;
            filling_r     <= 1'b1;
            win_sum_r     <= '0;
            win_shift_r   <= 4'd0;
            win_done_r    <= 1'b0;
            mean_r        <= '0;
            mean_v_r      <= 1'b0;
            speed_r       <= '0;
            speed_valid_r <= 1'b0;
            sat_r         <= 1'b0;
        end else begin
            // The pipeline keeps running through clear so in-flight results still emerge.
            mean_v_r      <= win_done_r;
            speed_valid_r <= mean_v_r;
            if (win_done_r) begin
                mean_r <= mean_s;
            end
            if (mean_v_r) begin
                speed_r <= sat_res_s[SPEED_W-1:0];
                sat_r   <= sat_res_s[SPEED_W];
            end

            if (bus.clear) begin
                mode_r     <= bus.mode;
                log2n_r    <= clamp_len(bus.meanlen);
                mask_r     <= len_mask(clamp_len(bus.meanlen));
                state_r    <= bus.mode ? ST_FILL : ST_ACC;
                sum_r      <= '0;
                cnt_r      <= '0;
                wp_r       <= '0;
                filling_r  <= 1'b1;
                win_done_r <= 1'b0;
            end else if (bus.sample) begin
                case (state_r)
                    ST_ACC, ST_DUMP: begin
                        if (last_s) begin
                            win_sum_r   <= sum_add_s;
                            win_shift_r <= log2n_r;
                            win_done_r  <= 1'b1;
                            sum_r       <= '0;
                            cnt_r       <= '0;
                            state_r     <= ST_DUMP;
                        end else begin
                            win_done_r  <= 1'b0;
                            sum_r       <= sum_add_s;
                            cnt_r       <= cnt_next_s;
                            state_r     <= ST_ACC;
                        end
                    end
                    ST_FILL: begin
                        sum_r <= sum_add_s;
                        wp_r  <= wp_next_s;
                        if (last_s) begin
                            win_sum_r   <= sum_add_s;
                            win_shift_r <= log2n_r;
                            win_done_r  <= 1'b1;
                            cnt_r       <= '0;
                            filling_r   <= 1'b0;
                            state_r     <= ST_RUN;
                        end else begin
                            win_done_r  <= 1'b0;
                            cnt_r       <= cnt_next_s;
                        end
                    end
                    ST_RUN: begin
                        sum_r       <= sum_slide_s;
                        wp_r        <= wp_next_s;
                        win_sum_r   <= sum_slide_s;
                        win_shift_r <= log2n_r;
                        win_done_r  <= 1'b1;
                    end
                    default: begin
                        state_r    <= mode_r ? ST_FILL : ST_ACC;
                        win_done_r <= 1'b0;
                    end
                endcase
            end else begin
                win_done_r <= 1'b0;
                if (state_r == ST_DUMP) begin
                    state_r <= ST_ACC;
                end
            end
        end
    end

    assign bus.speed       = speed_r;
    assign bus.speed_valid = speed_valid_r;
    assign bus.sat         = sat_r;
    assign bus.filling     = filling_r;

endmodule

// File: tb/tb_phase2speed_win.sv
// Directed bench for phase2speed_win: block/sliding means, latency, saturation,
// reset/clear behaviour and configuration latching.
module tb_phase2speed_win;

    logic clock = 1'b0;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;
    int spd_q[$];
    int sat_q[$];

    phase2speed_win_if #(.PHASE_W(19), .SPEED_W(16)) bus ();

    phase2speed_win #(
        .PHASE_W(19), .SPEED_W(16), .MAX_LOG2(10), .SCALE(20450), .SCALE_SHIFT(17)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Record every output pulse.
    always @(negedge clock) begin
        if (bus.speed_valid === 1'b1) begin
            spd_q.push_back(int'(bus.speed));
            sat_q.push_back(int'(bus.sat));
        end
    end

    task automatic push1(input int v);
        bus.sample = 1'b1;
        bus.phase  = 19'(v);
        @(negedge clock);
        bus.sample = 1'b0;
    endtask

    task automatic do_clear(input logic m, input logic [3:0] ml);
        bus.mode    = m;
        bus.meanlen = ml;
        bus.clear   = 1'b1;
        @(negedge clock);
        bus.clear   = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic reset_q();
        spd_q.delete();
        sat_q.delete();
    endtask

    function automatic int qget(input int k);
        return (k < spd_q.size()) ? spd_q[k] : -999999;
    endfunction

    function automatic int sget(input int k);
        return (k < sat_q.size()) ? sat_q[k] : -1;
    endfunction

    function automatic int xval(input int i);
        return ((i * 7919) % 4001) - 2000;
    endfunction

    function automatic int ref_speed(input longint sum, input int sh);
        longint mean;
        longint sp;
        mean = sum >>> sh;
        sp   = (mean * 64'sd20450) >>> 17;
        if (sp > 64'sd32767) sp = 64'sd32767;
        if (sp < -64'sd32768) sp = -64'sd32768;
        return int'(sp);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (bus.speed !== 16'sd0) begin n_err++; $display("FAIL reset_speed got %0d want 0", bus.speed); end
        n_cmp++; if (bus.speed_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.speed_valid); end
        n_cmp++; if (bus.sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", bus.sat); end
        n_cmp++; if (bus.filling !== 1'b1) begin n_err++; $display("FAIL reset_filling got %b want 1", bus.filling); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_block();
        do_clear(1'b0, 4'd2);
        reset_q();
        bus.phase  = 19'(1024);
        bus.sample = 1'b1;
        repeat (4) @(negedge clock);
        bus.sample = 1'b0;
        n_cmp++; if (bus.speed_valid !== 1'b0) begin n_err++; $display("FAIL block_lat0 got %b want 0", bus.speed_valid); end
        @(negedge clock);
        n_cmp++; if (bus.speed_valid !== 1'b0) begin n_err++; $display("FAIL block_lat1 got %b want 0", bus.speed_valid); end
        @(negedge clock);
        n_cmp++; if (bus.speed_valid !== 1'b1) begin n_err++; $display("FAIL block_lat2 got %b want 1", bus.speed_valid); end
        n_cmp++; if (bus.speed !== 16'sd159) begin n_err++; $display("FAIL block_pos got %0d want 159", bus.speed); end
        n_cmp++; if (bus.sat !== 1'b0) begin n_err++; $display("FAIL block_pos_sat got %b want 0", bus.sat); end
        @(negedge clock);
        n_cmp++; if (bus.speed_valid !== 1'b0) begin n_err++; $display("FAIL block_pulse_len got %b want 0", bus.speed_valid); end
        n_cmp++; if (bus.speed !== 16'sd159) begin n_err++; $display("FAIL block_hold got %0d want 159", bus.speed); end
        reset_q();
        for (int i = 0; i < 4; i++) push1(-1024);
        settle(5);
        n_cmp++; if (spd_q.size() !== 1) begin n_err++; $display("FAIL block_neg_count got %0d want 1", spd_q.size()); end
        n_cmp++; if (qget(0) !== -160) begin n_err++; $display("FAIL block_neg got %0d want -160", qget(0)); end
    endtask

    task automatic test_sliding();
        do_clear(1'b1, 4'd2);
        reset_q();
        n_cmp++; if (bus.filling !== 1'b1) begin n_err++; $display("FAIL slide_fill0 got %b want 1", bus.filling); end
        for (int i = 1; i <= 3; i++) push1(4096 * i);
        n_cmp++; if (bus.filling !== 1'b1) begin n_err++; $display("FAIL slide_fill3 got %b want 1", bus.filling); end
        push1(16384);
        n_cmp++; if (bus.filling !== 1'b0) begin n_err++; $display("FAIL slide_fill4 got %b want 0", bus.filling); end
        push1(20480);
        settle(5);
        n_cmp++; if (spd_q.size() !== 2) begin n_err++; $display("FAIL slide_count got %0d want 2", spd_q.size()); end
        n_cmp++; if (qget(0) !== 1597) begin n_err++; $display("FAIL slide_first got %0d want 1597", qget(0)); end
        // window 8192..20480 sums to 57344, mean 14336
        n_cmp++; if (qget(1) !== 2236) begin n_err++; $display("FAIL slide_second got %0d want 2236", qget(1)); end
    endtask

    task automatic test_saturation();
        do_clear(1'b0, 4'd0);
        reset_q();
        push1(262143);
        push1(-262144);
        settle(5);
        n_cmp++; if (qget(0) !== 32767) begin n_err++; $display("FAIL sat_pos got %0d want 32767", qget(0)); end
        n_cmp++; if (sget(0) !== 1) begin n_err++; $display("FAIL sat_pos_flag got %0d want 1", sget(0)); end
        n_cmp++; if (qget(1) !== -32768) begin n_err++; $display("FAIL sat_neg got %0d want -32768", qget(1)); end
        n_cmp++; if (sget(1) !== 1) begin n_err++; $display("FAIL sat_neg_flag got %0d want 1", sget(1)); end
        n_cmp++; if (bus.sat !== 1'b1) begin n_err++; $display("FAIL sat_hold got %b want 1", bus.sat); end
        push1(1000);
        settle(5);
        n_cmp++; if (qget(2) !== 156) begin n_err++; $display("FAIL sat_release got %0d want 156", qget(2)); end
        n_cmp++; if (sget(2) !== 0) begin n_err++; $display("FAIL sat_release_flag got %0d want 0", sget(2)); end
    endtask

    task automatic test_back_to_back();
        int  x[40];
        longint s;
        int  k;
        do_clear(1'b1, 4'd3);
        reset_q();
        for (int i = 0; i < 40; i++) begin
            x[i] = xval(i);
            push1(x[i]);
        end
        settle(5);
        n_cmp++; if (spd_q.size() !== 33) begin n_err++; $display("FAIL b2b_count got %0d want 33", spd_q.size()); end
        for (int i = 7; i < 40; i++) begin
            s = 0;
            for (int j = i - 7; j <= i; j++) s += longint'(x[j]);
            k = i - 7;
            n_cmp++;
            if (qget(k) !== ref_speed(s, 3)) begin
                n_err++;
                $display("FAIL b2b_out[%0d] got %0d want %0d", k, qget(k), ref_speed(s, 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.mode    = 1'b0;
        bus.meanlen = 4'd2;
        do_clear(1'b0, 4'd2);
        reset_q();
        push1(5000);
        push1(5000);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push1(2048);
        settle(5);
        n_cmp++; if (spd_q.size() !== 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", spd_q.size()); end
        n_cmp++; if (qget(0) !== 319) begin n_err++; $display("FAIL rstmid_speed got %0d want 319", qget(0)); end
    endtask

    task automatic test_config_latch();
        do_clear(1'b0, 4'd1);
        reset_q();
        bus.meanlen = 4'd0;
        push1(1024);
        push1(3072);
        settle(5);
        n_cmp++; if (spd_q.size() !== 1) begin n_err++; $display("FAIL latch_count got %0d want 1", spd_q.size()); end
        n_cmp++; if (qget(0) !== 319) begin n_err++; $display("FAIL latch_speed got %0d want 319", qget(0)); end
        do_clear(1'b0, 4'd15);
        reset_q();
        for (int i = 0; i < 1023; i++) push1(1024);
        settle(5);
        n_cmp++; if (spd_q.size() !== 0) begin n_err++; $display("FAIL clamp_early got %0d want 0", spd_q.size()); end
        push1(1024);
        settle(5);
        n_cmp++; if (spd_q.size() !== 1) begin n_err++; $display("FAIL clamp_count got %0d want 1", spd_q.size()); end
        n_cmp++; if (qget(0) !== 159) begin n_err++; $display("FAIL clamp_speed got %0d want 159", qget(0)); end
    endtask

    task automatic test_clear();
        do_clear(1'b0, 4'd1);
        reset_q();
        push1(1024);
        push1(1024);
        do_clear(1'b0, 4'd1);
        settle(4);
        n_cmp++; if (qget(0) !== 159) begin n_err++; $display("FAIL clear_inflight got %0d want 159", qget(0)); end
        do_clear(1'b0, 4'd1);
        n_cmp++; if (bus.speed !== 16'sd159) begin n_err++; $display("FAIL clear_keeps_speed got %0d want 159", bus.speed); end
        bus.clear  = 1'b1;
        bus.sample = 1'b1;
        bus.phase  = 19'(8192);
        @(negedge clock);
        bus.clear  = 1'b0;
        bus.sample = 1'b0;
        push1(2048);
        push1(2048);
        settle(5);
        n_cmp++; if (spd_q.size() !== 2) begin n_err++; $display("FAIL clear_count got %0d want 2", spd_q.size()); end
        n_cmp++; if (qget(1) !== 319) begin n_err++; $display("FAIL clear_drop got %0d want 319", qget(1)); end
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.mode    = 1'b0;
        bus.meanlen = 4'd2;
        bus.sample  = 1'b0;
        bus.phase   = '0;
        reset       = 1'b1;
        test_reset();
        test_block();
        test_sliding();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_config_latch();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
